// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared PC, resolve-state and EX branch record types
package cpu_pkg;
    localparam int PC_W = 16;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {IDLE, RECOVER} resolve_state_t;

    typedef struct packed {
        logic valid;
        logic branch;
        logic pred;
        pc_t  pc;
        pc_t  target;
    } ex_branch_t;
endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - ID prediction in, predictor update / redirect / flush out
interface branch_resolve_if;
    import cpu_pkg::*;

    logic valid_ID;
    logic is_branch_ID;
    pc_t  pc_ID;
    pc_t  target_ID;
    logic branch_predict_ID;
    logic taken_EX;
    logic branch_EX;
    logic branch_result_EX;
    pc_t  pc_EX;
    logic redirect_valid;
    pc_t  redirect_pc;
    logic flush;

    modport master (
        output valid_ID, is_branch_ID, pc_ID, target_ID, branch_predict_ID, taken_EX,
        input  branch_EX, branch_result_EX, pc_EX, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  valid_ID, is_branch_ID, pc_ID, target_ID, branch_predict_ID, taken_EX,
        output branch_EX, branch_result_EX, pc_EX, redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/branch_ex_reg.sv
// rtl/branch_ex_reg.sv - ID->EX branch record register; flush bubbles, stall holds
module branch_ex_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       stall,
    input  ex_branch_t d,
    output ex_branch_t q
);

    // Flush wins over stall so a stalled wrong-path slot is still killed.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX branch resolve, predictor update, redirect and flush FSM (optional BRANCH_STATS_EN counters)
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    branch_resolve_if.slave     bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    ex_branch_t     ex_d;
    ex_branch_t     ex_q;
    resolve_state_t state;
    resolve_state_t state_d;
    logic [2:0]     cnt;
    logic [2:0]     cnt_d;
    logic           resolve;
    logic           mispredict;
    logic           flush_c;

    always_comb begin
        ex_d.valid  = bus.valid_ID;
        ex_d.branch = bus.is_branch_ID;
        ex_d.pred   = bus.branch_predict_ID;
        ex_d.pc     = bus.pc_ID;
        ex_d.target = bus.target_ID;
    end

    branch_ex_reg u_ex_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_c),
        .stall (stall),
        .d     (ex_d),
        .q     (ex_q)
    );

    // Resolution is blocked in RECOVER: anything in EX there is wrong-path.
    assign resolve    = ex_q.valid & ex_q.branch & ~stall & (state == IDLE);
    assign mispredict = resolve & (ex_q.pred != bus.taken_EX);

    assign bus.branch_EX        = resolve;
    assign bus.branch_result_EX = bus.taken_EX;
    assign bus.pc_EX            = ex_q.pc;
    assign bus.redirect_valid   = mispredict;
    assign bus.redirect_pc      = mispredict ? (bus.taken_EX ? ex_q.target : ex_q.pc + pc_t'(1))
                                             : '0;
    assign bus.flush            = flush_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        flush_c = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    flush_c = 1'b1;
                    state_d = RECOVER;
                    cnt_d   = CNT_INIT;
                end
            end
            RECOVER: begin
                flush_c = 1'b1;
                if (!stall) begin
                    if (cnt == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve (FLUSH_CYCLES=2)
module tb_branch_resolve;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    logic stall;
    int   checks;
    int   errors;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_resolve_if bif ();

    branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (bif.slave)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic br, input logic [15:0] pc,
                          input logic [15:0] tgt, input logic pred);
        bif.valid_ID          = v;
        bif.is_branch_ID      = br;
        bif.pc_ID             = pc;
        bif.target_ID         = tgt;
        bif.branch_predict_ID = pred;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic do_branch(input logic [15:0] pc, input logic pred, input logic taken);
        set_id(1'b1, 1'b1, pc, 16'h0100, pred);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bif.taken_EX = taken;
        tick();
        if (pred != taken) begin
            tick();
            tick();
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        bif.taken_EX = 1'b0;
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_branch_EX", 32'(bif.branch_EX), 32'd0);
        chk("rst_flush", 32'(bif.flush), 32'd0);
        chk("rst_redirect_valid", 32'(bif.redirect_valid), 32'd0);
        chk("rst_redirect_pc", 32'(bif.redirect_pc), 32'd0);
        chk("rst_pc_EX", 32'(bif.pc_EX), 32'd0);

        // correct taken prediction
        set_id(1'b1, 1'b1, 16'h0010, 16'h0040, 1'b1);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bif.taken_EX = 1'b1;
        #1;
        chk("ok_branch_EX", 32'(bif.branch_EX), 32'd1);
        chk("ok_result", 32'(bif.branch_result_EX), 32'd1);
        chk("ok_pc_EX", 32'(bif.pc_EX), 32'h0010);
        chk("ok_redirect", 32'(bif.redirect_valid), 32'd0);
        chk("ok_flush", 32'(bif.flush), 32'd0);

        // mispredict: predicted NT, actually taken; wrong-path branches follow
        set_id(1'b1, 1'b1, 16'h0020, 16'h0080, 1'b0);
        tick();
        set_id(1'b1, 1'b1, 16'h0021, 16'h0099, 1'b0);
        #1;
        chk("mp_redirect", 32'(bif.redirect_valid), 32'd1);
        chk("mp_redirect_pc", 32'(bif.redirect_pc), 32'h0080);
        chk("mp_flush0", 32'(bif.flush), 32'd1);
        tick();
        chk("mp_flush1", 32'(bif.flush), 32'd1);
        chk("mp_wp_branch1", 32'(bif.branch_EX), 32'd0);
        tick();
        chk("mp_flush2", 32'(bif.flush), 32'd1);
        chk("mp_wp_branch2", 32'(bif.branch_EX), 32'd0);
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("mp_flush_end", 32'(bif.flush), 32'd0);
        chk("mp_bubble", 32'(bif.branch_EX), 32'd0);

        // PC wrap on not-taken fall-through
        set_id(1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b1);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bif.taken_EX = 1'b0;
        #1;
        chk("wrap_branch_EX", 32'(bif.branch_EX), 32'd1);
        chk("wrap_result", 32'(bif.branch_result_EX), 32'd0);
        chk("wrap_redirect", 32'(bif.redirect_valid), 32'd1);
        chk("wrap_redirect_pc", 32'(bif.redirect_pc), 32'h0000);
        tick();
        tick();
        tick();
        chk("wrap_flush_end", 32'(bif.flush), 32'd0);

        // stall in resolve cycle for 4 cycles, then mispredict on release
        set_id(1'b1, 1'b1, 16'h0030, 16'h0050, 1'b0);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        stall = 1'b1;
        bif.taken_EX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall_branch_EX%0d", i), 32'(bif.branch_EX), 32'd0);
            chk($sformatf("stall_redirect%0d", i), 32'(bif.redirect_valid), 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("rel_branch_EX", 32'(bif.branch_EX), 32'd1);
        chk("rel_redirect", 32'(bif.redirect_valid), 32'd1);
        chk("rel_redirect_pc", 32'(bif.redirect_pc), 32'h0050);

        // stall on 2nd flush cycle for 3 cycles; ID carries a branch that must be bubbled
        set_id(1'b1, 1'b1, 16'h0060, 16'h0070, 1'b0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rs_flush%0d", i), 32'(bif.flush), 32'd1);
            chk($sformatf("rs_branch_EX%0d", i), 32'(bif.branch_EX), 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("rs_flush_a", 32'(bif.flush), 32'd1);
        tick();
        chk("rs_flush_b", 32'(bif.flush), 32'd1);
        tick();
        chk("rs_flush_end", 32'(bif.flush), 32'd0);
        chk("rs_bubble", 32'(bif.branch_EX), 32'd0);
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        // reset mid-RECOVER
        set_id(1'b1, 1'b1, 16'h0070, 16'h0090, 1'b1);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bif.taken_EX = 1'b0;
        #1;
        chk("rr_redirect_pc", 32'(bif.redirect_pc), 32'h0071);
        tick();
        chk("rr_in_recover", 32'(bif.flush), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rr_flush", 32'(bif.flush), 32'd0);
        chk("rr_branch_EX", 32'(bif.branch_EX), 32'd0);
        chk("rr_pc_EX", 32'(bif.pc_EX), 32'd0);
        set_id(1'b1, 1'b1, 16'h0080, 16'h00A0, 1'b1);
        tick();
        set_id(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bif.taken_EX = 1'b1;
        #1;
        chk("rr_idle_resolve", 32'(bif.branch_EX), 32'd1);
        chk("rr_idle_noflush", 32'(bif.flush), 32'd0);

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_branch(16'h0100, 1'b1, 1'b1);
        do_branch(16'h0101, 1'b0, 1'b1);
        do_branch(16'h0102, 1'b0, 1'b0);
        do_branch(16'h0103, 1'b1, 1'b0);
        do_branch(16'h0104, 1'b1, 1'b1);
        chk("stat_branches", stat_branches, 32'd5);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("stat_branches_rst", stat_branches, 32'd0);
        chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the 2-bit-counter branch predictor's ID-stage prediction.
- Carries prediction, PC and target from ID into EX, holding them under stall.
- Compares the prediction against the actual branch outcome and drives the predictor update port (branch_EX, branch_result_EX, pc_EX).
- On a mispredict, issues a PC redirect and runs a wrong-path flush sequence that kills the IF/ID pipeline.

Parameters:
- PC_W, 16, PC width; PC is an instruction index, so fall-through is PC+1.
- FLUSH_CYCLES, 2, number of cycles flush is high after a mispredict (covers the IF slot, the ID slot and the predictor's 1-cycle read latency). Legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; holds the EX register and the recovery counter
- valid_ID  in  1  ID slot holds a real instruction
- is_branch_ID  in  1  ID instruction is a conditional branch
- pc_ID  in  PC_W  PC of the ID instruction
- target_ID  in  PC_W  taken-target computed in ID
- branch_predict_ID  in  1  predictor output for the ID instruction
- taken_EX  in  1  actual outcome from the EX comparator, valid when branch_EX=1
- branch_EX  out  1  predictor update enable
- branch_result_EX  out  1  update direction (equals taken_EX)
- pc_EX  out  PC_W  update address for the predictor
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  PC_W  corrected fetch PC
- flush  out  1  kill IF/ID contents this cycle

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - EX register: valid=0, branch=0, pred=0, pc=0, target=0.
  - FSM=IDLE, counter=0.
  - All outputs 0.
- EX register update, priority rst > flush > stall > load:
  - flush=1: load a bubble (valid=0). This overrides stall.
  - else stall=1: hold.
  - else: capture valid_ID, is_branch_ID, pc_ID, target_ID, branch_predict_ID.
- Resolve condition: resolve = ex_valid & ex_branch & ~stall & (state==IDLE).
- Predictor update (combinational from the EX register and taken_EX):
  - branch_EX = resolve.
  - branch_result_EX = taken_EX.
  - pc_EX = ex_pc (driven even when branch_EX=0).
- Mispredict: mispredict = resolve & (ex_pred != taken_EX).
  - redirect_valid = mispredict (combinational, same cycle as resolve).
  - redirect_pc = taken_EX ? ex_target : ex_pc+1, computed modulo 2^PC_W (0xFFFF+1 wraps to 0x0000).
- FSM:
  - IDLE: on mispredict → RECOVER, counter = FLUSH_CYCLES-1. flush=1 in the mispredict cycle itself.
  - RECOVER: flush=1.
    - ~stall & counter==0 → IDLE.
    - ~stall otherwise → counter decrements.
    - stall → hold.
  - With FLUSH_CYCLES=1, RECOVER lasts one cycle.
- Flush length: flush is high for exactly FLUSH_CYCLES+1 unstalled cycles per mispredict (the mispredict cycle plus RECOVER).
- Wrong-path suppression: no update or redirect is issued in RECOVER; any EX contents there are wrong-path and already bubbled.
- Correct prediction: no redirect, no flush; update still fires.
- Non-branch or invalid EX: no update, no redirect.
- Stall in the resolve cycle: nothing fires; resolution occurs on the first unstalled cycle, exactly once.
- rst during RECOVER: next cycle IDLE, flush=0, EX bubble.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each resolve; stat_mispredicts increments on each mispredict.
  - Both wrap at 2^32 and clear on rst.
- When undefined: ports and logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg gets:
  - typedef pc_t (logic [PC_W-1:0]).
  - typedef resolve_state_t enum {IDLE, RECOVER}.
  - struct ex_branch_t {valid, branch, pred, pc, target}.
- Sub-module branch_ex_reg: the stall/flush-controlled ID→EX register. The top keeps the FSM, compare logic and counters.

Test Plan:
- Predicted-taken branch, pc_ID=0x0010, target=0x0040, taken_EX=1 → branch_EX=1, branch_result_EX=1, pc_EX=0x0010, redirect_valid=0, flush=0.
- Predicted not-taken, pc=0x0020, target=0x0080, taken_EX=1 → redirect_valid=1, redirect_pc=0x0080; flush high 3 consecutive cycles (FLUSH_CYCLES=2); the two following wrong-path branches produce no branch_EX.
- Predicted taken, pc=0xFFFF, taken_EX=0 → redirect_pc=0x0000 (wrap), branch_result_EX=0.
- Branch in EX with stall=1 for 4 cycles, then released → branch_EX=0 during the stall, then exactly one pulse; a mispredict redirect fires on the release cycle.
- Mispredict followed by stall=1 on the 2nd flush cycle for 3 cycles → flush stays high through the stall; IDLE is reached after the remaining unstalled count; EX is loaded with bubbles throughout.
- rst asserted mid-RECOVER → next cycle flush=0, branch_EX=0, state IDLE. With BRANCH_STATS_EN: after 5 branches with 2 mispredicts, stat_branches=5, stat_mispredicts=2; both return to 0 after rst.
